// File: rtl/mmio_timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer:
// register word offsets, CTRL field positions, mode encodings, FSM states.
package mmio_timer_pkg;

    // Word offsets within the 16-byte window (addr[3:2])
    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    // CTRL field positions; only the low CTRL_W bits are stored
    localparam int CTRL_W       = 4;
    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;

    // MODE encodings; 2'b1x behaves like auto-reload
    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

endpackage

// File: rtl/mmio_timer_byte_merge.sv
// Combinational 32-bit old/new merge under per-byte enables.
// Reusable by any bridge peripheral that takes lane-aligned stores.
module mmio_timer_byte_merge (
    input  logic [31:0] i_old,
    input  logic [31:0] i_new,
    input  logic [3:0]  i_byteen,
    output logic [31:0] o_merged
);

    // Each enabled byte lane takes the new data, the rest keep the old value
    always_comb begin
        o_merged = i_old;
        for (int i = 0; i < 4; i++) begin
            if (i_byteen[i]) begin
                o_merged[8*i +: 8] = i_new[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/mmio_timer.sv
// Memory-mapped countdown timer: CTRL / PRESET / COUNT registers,
// combinational loads, byte-enabled stores, level interrupt on expiry.
module mmio_timer
    import mmio_timer_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_7F00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    logic [CTRL_W-1:0] r_ctrl;
    logic [31:0]       r_preset;
    logic [31:0]       r_count;
    logic              r_flag;
    state_t            r_state;

    logic [1:0]  w_off;
    logic        w_store;
    logic        w_st_ctrl;
    logic        w_st_preset;
    logic [31:0] w_old;
    logic [31:0] w_merged;
    logic        w_en;
    logic        w_reload;
    logic        w_unused_addr;

    state_t      w_state_nxt;
    logic [31:0] w_count_nxt;
    logic        w_flag_set;
    logic        w_flag_auto_clr;
    logic        w_en_clr;

    assign w_off         = addr[3:2];
    assign w_unused_addr = ^addr[1:0];
    assign hit           = (addr[31:4] == BASE[31:4]) && (w_off != 2'b11);
    assign w_store       = hit && (byteen != 4'b0000);
    assign w_st_ctrl     = w_store && (w_off == CTRL_OFF);
    assign w_st_preset   = w_store && (w_off == PRESET_OFF);

    assign w_en     = r_ctrl[CTRL_EN];
    assign w_reload = (r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) || r_ctrl[CTRL_MODE_HI];

    // Register selected by the offset; doubles as the "old" side of a store merge
    always_comb begin
        case (w_off)
            CTRL_OFF:   w_old = {{(32-CTRL_W){1'b0}}, r_ctrl};
            PRESET_OFF: w_old = r_preset;
            COUNT_OFF:  w_old = r_count;
            default:    w_old = 32'h0;
        endcase
    end

    assign rdata = hit ? w_old : 32'h0;
    assign irq   = r_flag & r_ctrl[CTRL_IM];

    mmio_timer_byte_merge u_merge (
        .i_old    (w_old),
        .i_new    (wdata),
        .i_byteen (byteen),
        .o_merged (w_merged)
    );

    // Next-state and COUNT update, all decided from pre-edge register values
    always_comb begin
        w_state_nxt     = r_state;
        w_count_nxt     = r_count;
        w_flag_set      = 1'b0;
        w_flag_auto_clr = 1'b0;
        w_en_clr        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_en) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                // A disable that lands here returns to IDLE without an extra CNT cycle
                if (!w_en) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_count_nxt = r_preset;
                    w_state_nxt = ST_CNT;
                end
            end
            ST_CNT: begin
                if (!w_en) begin
                    w_state_nxt = ST_IDLE;
                end else if (r_count > 32'd1) begin
                    w_count_nxt = r_count - 32'd1;
                end else begin
                    w_count_nxt = 32'd0;
                    w_flag_set  = 1'b1;
                    w_state_nxt = ST_INT;
                end
            end
            ST_INT: begin
                w_state_nxt = ST_IDLE;
                if (w_reload) w_flag_auto_clr = 1'b1;
                else          w_en_clr        = 1'b1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM state and COUNT registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_count <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // CTRL: a CPU store takes priority over the one-shot EN clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ctrl <= '0;
        end else if (w_st_ctrl) begin
            r_ctrl <= w_merged[CTRL_W-1:0];
        end else if (w_en_clr) begin
            r_ctrl[CTRL_EN] <= 1'b0;
        end
    end

    // PRESET: plain byte-merged store target, only sampled in LOAD
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_preset <= 32'd0;
        end else if (w_st_preset) begin
            r_preset <= w_merged;
        end
    end

    // Expiry flag: setting beats any same-edge clear
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_flag <= 1'b0;
        end else if (w_flag_set) begin
            r_flag <= 1'b1;
        end else if (w_st_ctrl || w_st_preset || w_flag_auto_clr) begin
            r_flag <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mmio_timer.sv
// Self-checking bench for mmio_timer: directed steps from the test plan,
// then randomized stores checked against a behavioural reference model.
module tb_mmio_timer;

    localparam logic [31:0] BASE   = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL = BASE;
    localparam logic [31:0] A_PRE  = BASE + 32'd4;
    localparam logic [31:0] A_CNT  = BASE + 32'd8;
    localparam logic [31:0] A_HOLE = BASE + 32'd12;

    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_CNT  = 2;
    localparam int PH_INT  = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [3:0]  byteen = 4'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata;
    logic        hit;
    logic        irq;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [3:0]  m_ctrl;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    int          m_ph;
    logic        m_flag;

    logic [31:0] rd_d;
    logic        rd_h;

    always #5 clk = ~clk;

    mmio_timer #(.BASE(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .hit    (hit),
        .irq    (irq)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic m_hit(input logic [31:0] a);
        return (a[31:4] == BASE[31:4]) && (a[3:2] != 2'b11);
    endfunction

    function automatic logic [31:0] m_reg(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[3:2])
            2'd0:    return {28'h0, m_ctrl};
            2'd1:    return m_preset;
            default: return m_count;
        endcase
    endfunction

    task automatic m_reset();
        m_ctrl = 4'h0; m_preset = 32'h0; m_count = 32'h0; m_ph = PH_IDLE; m_flag = 1'b0;
    endtask

    // One clock edge of the timer as described by its register/FSM rules
    task automatic m_edge(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        logic [3:0]  c;
        logic [31:0] p, n, mg;
        int          ph;
        logic        f, set, st, en, oneshot;
        c = m_ctrl; p = m_preset; n = m_count; ph = m_ph; f = m_flag; set = 1'b0;
        en = m_ctrl[0];
        oneshot = (m_ctrl[2:1] == 2'b00);
        case (m_ph)
            PH_IDLE: if (en) ph = PH_LOAD;
            PH_LOAD: if (en) begin n = m_preset; ph = PH_CNT; end else ph = PH_IDLE;
            PH_CNT: begin
                if (!en) ph = PH_IDLE;
                else if (m_count <= 32'd1) begin n = 32'd0; set = 1'b1; ph = PH_INT; end
                else n = m_count - 32'd1;
            end
            default: begin
                ph = PH_IDLE;
                if (oneshot) c[0] = 1'b0; else f = 1'b0;
            end
        endcase
        st = m_hit(a) && (be != 4'h0);
        mg = m_reg(a);
        for (int i = 0; i < 4; i++) if (be[i]) mg[8*i +: 8] = wd[8*i +: 8];
        if (st && a[3:2] == 2'd0) begin c = mg[3:0]; f = 1'b0; end
        if (st && a[3:2] == 2'd1) begin p = mg; f = 1'b0; end
        if (set) f = 1'b1;
        m_ctrl = c; m_preset = p; m_count = n; m_ph = ph; m_flag = f;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a);
        addr = a; byteen = 4'h0;
        #1;
        rd_d = rdata; rd_h = hit;
    endtask

    task automatic tick(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
        addr = a; byteen = be; wdata = wd;
        m_edge(a, be, wd);
        @(posedge clk);
        #1;
        byteen = 4'h0; wdata = 32'h0;
    endtask

    task automatic idle();
        tick(A_CTRL, 4'h0, 32'h0);
    endtask

    task automatic check_model(input string tag);
        rd(A_CTRL); chk({tag, ".ctrl"},   rd_d, m_reg(A_CTRL));
        rd(A_PRE);  chk({tag, ".preset"}, rd_d, m_reg(A_PRE));
        rd(A_CNT);  chk({tag, ".count"},  rd_d, m_reg(A_CNT));
        chk({tag, ".irq"}, {31'h0, irq}, {31'h0, m_flag & m_ctrl[3]});
    endtask

    initial begin
        logic        found;
        logic [31:0] ra, wd;
        int          op;

        // Reset state
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        rd(A_CTRL); chk("rst_ctrl", rd_d, 32'h0); chk("rst_hit0", {31'h0, rd_h}, 32'h1);
        rd(A_PRE);  chk("rst_pre",  rd_d, 32'h0); chk("rst_hit4", {31'h0, rd_h}, 32'h1);
        rd(A_CNT);  chk("rst_cnt",  rd_d, 32'h0); chk("rst_hit8", {31'h0, rd_h}, 32'h1);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        rd(A_HOLE); chk("hole_hit", {31'h0, rd_h}, 32'h0); chk("hole_rd", rd_d, 32'h0);
        rd(32'h0001_7F04); chk("far_hit", {31'h0, rd_h}, 32'h0);
        @(negedge clk);
        reset = 1'b1;

        // One-shot, PRESET=5: COUNT 5..0, irq on edge 7, held
        tick(A_PRE, 4'hF, 32'd5);
        tick(A_CTRL, 4'hF, 32'h9);
        for (int e = 1; e <= 9; e++) begin
            idle();
            check_model("oneshot");
            rd(A_CNT);
            if (e >= 2 && e <= 7) chk("os_count", rd_d, 32'(7 - e));
            chk("os_irq", {31'h0, irq}, {31'h0, (e >= 7)});
        end
        rd(A_CTRL); chk("os_ctrl_after", rd_d, 32'h8);
        tick(A_CTRL, 4'h1, 32'h0);
        check_model("os_clear");
        chk("os_irq_drop", {31'h0, irq}, 32'h0);

        // Auto-reload, PRESET=3
        tick(A_PRE, 4'hF, 32'd3);
        tick(A_CTRL, 4'h1, 32'hB);
        for (int e = 0; e < 20; e++) begin
            idle();
            check_model("reload");
        end
        found = 1'b0;
        for (int e = 0; e < 10 && !found; e++) begin
            idle();
            check_model("reload_seek");
            rd(A_CNT);
            if (rd_d == 32'd2) found = 1'b1;
        end
        chk("reload_seek_found", {31'h0, found}, 32'h1);
        tick(A_CTRL, 4'h1, 32'h0);
        for (int e = 0; e < 4; e++) begin
            idle();
            check_model("freeze");
            rd(A_CNT); chk("freeze_count", rd_d, 32'd1);
        end
        tick(A_CNT, 4'hF, 32'h0000_FFFF);
        check_model("count_ro");
        rd(A_CNT); chk("count_ro_val", rd_d, 32'd1);

        // Byte-enabled PRESET stores
        tick(A_PRE, 4'hF, 32'h1122_3344);
        tick(A_PRE, 4'b0001, 32'hAABB_CCDD);
        rd(A_PRE); chk("be_0001", rd_d, 32'h1122_33DD);
        tick(A_PRE, 4'b1100, 32'hAABB_CCDD);
        rd(A_PRE); chk("be_1100", rd_d, 32'hAABB_33DD);
        rd(A_PRE + 32'd3); chk("low_addr_ignored", rd_d, 32'hAABB_33DD);
        tick(A_HOLE, 4'hF, 32'hFFFF_FFFF);
        check_model("hole_store");

        // PRESET=0 expires two edges after LOAD
        tick(A_PRE, 4'hF, 32'd0);
        tick(A_CTRL, 4'h1, 32'h9);
        for (int e = 1; e <= 3; e++) begin
            idle();
            check_model("preset0");
            chk("p0_irq", {31'h0, irq}, {31'h0, (e == 3)});
        end

        // Async reset with irq high drops irq without a clock edge
        #1;
        reset = 1'b0;
        m_reset();
        #1;
        chk("rst_async_irq", {31'h0, irq}, 32'h0);
        check_model("rst_async");
        @(negedge clk);
        reset = 1'b1;

        // Async reset while COUNT=3 in CNT
        tick(A_PRE, 4'hF, 32'd6);
        tick(A_CTRL, 4'h1, 32'h9);
        found = 1'b0;
        for (int e = 0; e < 12 && !found; e++) begin
            idle();
            rd(A_CNT);
            if (rd_d == 32'd3) found = 1'b1;
        end
        chk("mid_seek_found", {31'h0, found}, 32'h1);
        reset = 1'b0;
        m_reset();
        #1;
        rd(A_CTRL); chk("mid_rst_ctrl", rd_d, 32'h0);
        rd(A_PRE);  chk("mid_rst_pre",  rd_d, 32'h0);
        rd(A_CNT);  chk("mid_rst_cnt",  rd_d, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int e = 0; e < 4; e++) begin
            idle();
            check_model("post_rst");
            rd(A_CNT); chk("post_rst_cnt", rd_d, 32'h0);
        end

        // Randomized stores against the model
        for (int cyc = 0; cyc < 400; cyc++) begin
            op = int'($urandom_range(0, 9));
            wd = $urandom;
            case (op)
                0, 1: begin
                    wd[0] = ($urandom_range(0, 9) < 7);
                    tick(A_CTRL | 32'($urandom_range(0, 3)), 4'($urandom_range(1, 15)), wd);
                end
                2: begin
                    wd[7:0] = 8'($urandom_range(0, 7));
                    tick(A_PRE, 4'b0001, wd);
                end
                3: tick(A_CNT, 4'($urandom_range(1, 15)), wd);
                4: tick(($urandom_range(0, 1) == 0) ? A_HOLE : (BASE + 32'h10),
                        4'($urandom_range(1, 15)), wd);
                default: idle();
            endcase
            check_model("rand");
            case ($urandom_range(0, 2))
                0:       ra = BASE | 32'($urandom_range(0, 15));
                1:       ra = $urandom;
                default: ra = BASE ^ (32'h1 << $urandom_range(4, 31));
            endcase
            rd(ra);
            chk("rand_hit", {31'h0, rd_h}, {31'h0, m_hit(ra)});
            chk("rand_rdata", rd_d, m_reg(ra));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_timer.md
Name: mmio_timer

Overview:
- Memory-mapped countdown timer that sits at the far end of the CPU data-memory port (addr / wdata / byteen / rdata).
- The system bridge routes data accesses to this block when `hit` is asserted.
- It answers loads combinationally in the same cycle as the M-stage address, and accepts byte-enabled stores on the clock edge.
- It raises `irq` toward the CPU when the count expires.

Parameters:
- BASE, 32'h0000_7F00, base address of the 16-byte register window; bits [3:0] must be 0.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0); clears all state immediately.
- addr  in  32  byte address from the CPU data port.
- byteen  in  4  byte write enables; any nonzero value is a store.
- wdata  in  32  store data, already lane-aligned by the CPU.
- rdata  out  32  load data for `addr`; combinational.
- hit  out  1  `addr` decodes to a valid register of this block.
- irq  out  1  interrupt request, level.

Behaviour:
- Address decode:
  - `hit` = (addr[31:4] == BASE[31:4]) && (addr[3:2] != 2'b11).
  - addr[1:0] is ignored.
  - Offset 0x0 = CTRL, 0x4 = PRESET, 0x8 = COUNT.
- Register fields:
  - CTRL[0] EN: count enable.
  - CTRL[2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as 01.
  - CTRL[3] IM: interrupt mask enable.
  - CTRL[31:4] read as 0 and are not stored.
- Reads:
  - rdata = selected register when `hit`, else 32'h0.
  - A read has no side effects.
- Writes:
  - Taken only when `hit` && byteen != 0.
  - Byte merge: for each i, byte i = byteen[i] ? wdata byte i : old byte i.
  - COUNT is read-only; stores to it are dropped.
- Reset values: CTRL = 0, PRESET = 0, COUNT = 0, state = IDLE, irq flag = 0. Therefore irq = 0 and rdata = 0 for every addr.
- FSM states: IDLE, LOAD, CNT, INT. Transitions are evaluated on each edge using register values from before that edge.
  - IDLE: EN=1 -> LOAD; otherwise stay.
  - LOAD: COUNT <= PRESET, then -> CNT.
  - CNT:
    - EN=0 -> IDLE, COUNT holds.
    - Else if COUNT > 1: COUNT <= COUNT - 1, stay in CNT.
    - Else: COUNT <= 0, set irq flag, -> INT.
  - INT:
    - MODE=00: clear EN, -> IDLE.
    - MODE=01: -> IDLE, EN kept, so the timer reloads on the next cycle.
- Latency: from EN written to 1 with PRESET = N >= 1, the irq flag is set on edge N+2 after the store edge (store -> IDLE sees EN -> LOAD -> N CNT cycles).
- IRQ:
  - irq = flag & CTRL.IM.
  - One-shot: the flag stays set until any store to CTRL or PRESET clears it.
  - Auto-reload: the flag clears automatically one cycle after being set (one-cycle pulse).
- Boundary conditions:
  - PRESET = 0 or 1: LOAD puts 0 or 1 in COUNT, and CNT goes straight to INT on the next edge.
  - Unsigned arithmetic; COUNT never wraps below 0.
- Simultaneous events:
  - A CPU store to CTRL on the same edge the FSM clears EN (INT, one-shot): the CPU value wins.
  - A store clearing EN while in LOAD or CNT: FSM reaches IDLE within one edge of EN=0 being visible.
  - A PRESET store during CNT affects only the next LOAD.
  - A store that clears the flag on the same edge the flag is being set: the set wins.
- Reset mid-count: all state returns to reset values asynchronously, and irq drops in the same cycle reset goes low.

Decomposition:
- Shared package/header (alongside const.v):
  - Register offsets: CTRL_OFF, PRESET_OFF, COUNT_OFF.
  - CTRL bit positions: EN, MODE, IM.
  - MODE encodings.
  - FSM state encodings.
- One natural sub-module: `byte_merge`, a combinational 32-bit old/new merge under a 4-bit byteen. It is reusable by other bridge peripherals.

Test Plan:
- Reset then read 0x7F00 / 0x7F04 / 0x7F08 -> rdata 0, irq 0, hit 1. Read 0x7F0C -> hit 0, rdata 0.
- Store PRESET = 5, then CTRL = 32'h9 (EN, one-shot, IM) -> COUNT reads 5, 4, 3, 2, 1, 0 on successive cycles. irq rises 7 edges after the CTRL store and holds; CTRL reads 32'h8. A CTRL store of 0 drops irq the next cycle.
- Auto-reload: PRESET = 3, CTRL = 32'hB -> irq one-cycle pulses every 5 cycles and COUNT cycles 3, 2, 1, 0. CTRL store of 0 mid-count -> COUNT freezes, no further pulses.
- Byte writes to PRESET:
  - byteen = 4'b0001, wdata = 32'hAABBCCDD, old PRESET 32'h11223344 -> PRESET reads 32'h112233DD.
  - byteen = 4'b1100 -> 32'hAABB33DD.
  - Store to COUNT -> unchanged.
- Edge cases:
  - PRESET = 0 with EN set -> INT 2 edges after LOAD, COUNT 0.
  - Assert reset low while COUNT = 3 in CNT -> irq 0 and all reads 0 immediately; after release the FSM stays IDLE.
